alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Reservation station directly upstream of the integer ALU. Accepts renamed ALU uops from dispatch,
//  holds them until both source operands are available (captured from dispatch or snooped off the CDB),
//  and selects the oldest ready uop each cycle for the ALU. Issue outputs drive the ALU's
//  valid/op/operand/tag inputs one-to-one; the ALU always accepts, so there is no issue backpressure.
// PARAMETERS
//  DEPTH    8   number of entries (power of two, 2..16)
//  PTAG_W   6   physical register tag width
//  ROB_W    6   ROB tag width
//  XLEN     32  operand/result width
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst_n           in   1       reset, asynchronous, active-low
//  flush_i         in   1       pipeline flush: discard all entries
//  disp_valid_i    in   1       dispatch uop present
//  disp_ready_o    out  1       queue can accept a uop this cycle
//  disp_op_i       in   3       ALU op (ADD/SUB/AND/OR/XOR encoding as ALU)
//  disp_src{1,2}_tag_i  in PTAG_W  source physical tags
//  disp_src{1,2}_rdy_i  in 1       source value already valid at dispatch
//  disp_src{1,2}_val_i  in XLEN    source value (meaningful when rdy=1)
//  disp_rd_p_i     in   PTAG_W  destination physical tag
//  disp_rob_tag_i  in   ROB_W   ROB tag
//  cdb_valid_i     in   1       CDB broadcast valid
//  cdb_tag_i       in   PTAG_W  broadcast destination tag
//  cdb_data_i      in   XLEN    broadcast result
//  iss_valid_o     out  1       uop issued to ALU this cycle
//  iss_op_o        out  3       ALU op
//  iss_op1_o, iss_op2_o out XLEN operand values
//  iss_rd_p_o      out  PTAG_W  destination tag
//  iss_rob_tag_o   out  ROB_W   ROB tag
//  occupancy_o     out  $clog2(DEPTH)+1  valid entry count
// BEHAVIOUR
//  - Reset: all entry valid bits 0; occupancy_o=0; iss_valid_o=0; disp_ready_o=1; age state cleared.
//  - Dispatch: accepted when disp_valid_i & disp_ready_o & !flush_i; written into lowest-index free
//    entry; disp_ready_o = (occupancy < DEPTH), from current state only (slot freed by same-cycle issue
//    is not reusable until next cycle). Accepted uop is youngest.
//  - Dispatch-time snoop: if a source has rdy=0 and cdb_valid_i & cdb_tag_i==src_tag that cycle,
//    entry stores cdb_data_i and marks the source ready (no missed wakeup).
//  - Wakeup: each cycle every valid entry compares both pending source tags with cdb_tag_i; on match
//    captures cdb_data_i and sets that source ready at the clock edge. Both sources may wake in the
//    same cycle (same tag).
//  - Select: combinational from registered state; among valid entries with both sources ready pick the
//    oldest (age matrix). iss_valid_o=1 iff such an entry exists and !flush_i. Issued entry freed at
//    the edge. Exactly one issue per cycle max. Zero-latency path: entry dispatched in cycle N is
//    eligible no earlier than N+1.
//  - Occupancy: +1 on accepted dispatch, -1 on issue, unchanged when both; never exceeds DEPTH.
//  - Flush: synchronous; clears all valid bits and occupancy at next edge; wins over dispatch, wakeup
//    and issue in same cycle; iss_valid_o forced 0 while flush_i=1.
//  - Reset asserted mid-operation: all entries discarded immediately (async), outputs to reset values.
//  - iss_* data outputs are don't-care when iss_valid_o=0.
// CONFIGURATION
//  IQ_SAME_CYCLE_WAKEUP_EN defined: an entry whose last pending source matches the CDB this cycle is
//    select-eligible this cycle; its operand is forwarded from cdb_data_i to iss_op*_o (CDB->issue
//    combinational path). Oldest-first still applies across woken and already-ready entries.
//  Not defined: woken entries become eligible the cycle after the broadcast (one-cycle wakeup bubble).
// STRUCTURE
//  - Shared package ooo_pkg: alu_op_e enum (3-bit, ADD=0..XOR=4), PTAG_W/ROB_W/XLEN constants,
//    iq_entry_t struct {valid, op, src1/src2 tag, rdy, val, rd_p, rob_tag}.
//  - One sub-module: iq_age_matrix (DEPTH x DEPTH age bits; alloc/free inputs, request vector in,
//    one-hot oldest grant out). Entry array, wakeup and occupancy stay in this module.
// TESTING
//  1. Reset, dispatch ADD src1=10 src2=20 both rdy -> next cycle iss_valid_o=1, op1=10, op2=20,
//     occupancy 1->0.
//  2. Dispatch SUB src1 tag 5 not ready; CDB tag5 data 0x77 at cycle N -> issue at N+1 with op1=0x77
//     (macro off); issue at N with op1=0x77 (macro on).
//  3. Fill 8 entries none ready -> disp_ready_o=0 and 9th dispatch held; wake entry 3 -> it issues,
//     disp_ready_o=1 the following cycle.
//  4. Dispatch A then B, both wait tag 9; single CDB tag 9 -> A issues first, B next cycle (oldest-first).
//  5. Dispatch with src tag 12 not ready while CDB broadcasts tag 12 same cycle -> entry captures data,
//     issues next cycle.
//  6. Queue holding 5 entries, flush_i with simultaneous dispatch -> iss_valid_o=0, occupancy 0 next
//     cycle, dispatched uop dropped.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ALU op encoding, datapath widths and the
// issue-queue entry layout.
package ooo_pkg;

  localparam int unsigned PTAG_W = 6;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned XLEN   = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    alu_op_e           op;
    logic [PTAG_W-1:0] src1_tag;
    logic              src1_rdy;
    logic [XLEN-1:0]   src1_val;
    logic [PTAG_W-1:0] src2_tag;
    logic              src2_rdy;
    logic [XLEN-1:0]   src2_val;
    logic [PTAG_W-1:0] rd_p;
    logic [ROB_W-1:0]  rob_tag;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: r_older[i][j]=1 means entry i was allocated
// before entry j. Grants the single oldest requester (one-hot).
module iq_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [DEPTH-1:0][DEPTH-1:0] w_older_nxt;

  // A new entry is younger than everything: clear its row, set its column.
  always_comb begin
    w_older_nxt = r_older;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (i_free[i] || i_free[j] || i_alloc[i]) begin
          w_older_nxt[i][j] = 1'b0;
        end else if (i_alloc[j] && (i != j)) begin
          w_older_nxt[i][j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_older <= '0;
    end else if (i_flush) begin
      r_older <= '0;
    end else begin
      r_older <= w_older_nxt;
    end
  end

  always_comb begin
    o_grant = i_req;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (i_req[j] && r_older[j][i]) begin
          o_grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: captures operands at dispatch or from the CDB and
// issues the oldest ready uop. Define IQ_SAME_CYCLE_WAKEUP_EN to let a CDB hit issue in the same cycle.
module alu_issue_queue
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTAG_W = ooo_pkg::PTAG_W,
  parameter int unsigned ROB_W  = ooo_pkg::ROB_W,
  parameter int unsigned XLEN   = ooo_pkg::XLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic [2:0]             disp_op_i,
  input  logic [PTAG_W-1:0]      disp_src1_tag_i,
  input  logic [PTAG_W-1:0]      disp_src2_tag_i,
  input  logic                   disp_src1_rdy_i,
  input  logic                   disp_src2_rdy_i,
  input  logic [XLEN-1:0]        disp_src1_val_i,
  input  logic [XLEN-1:0]        disp_src2_val_i,
  input  logic [PTAG_W-1:0]      disp_rd_p_i,
  input  logic [ROB_W-1:0]       disp_rob_tag_i,
  input  logic                   cdb_valid_i,
  input  logic [PTAG_W-1:0]      cdb_tag_i,
  input  logic [XLEN-1:0]        cdb_data_i,
  output logic                   iss_valid_o,
  output logic [2:0]             iss_op_o,
  output logic [XLEN-1:0]        iss_op1_o,
  output logic [XLEN-1:0]        iss_op2_o,
  output logic [PTAG_W-1:0]      iss_rd_p_o,
  output logic [ROB_W-1:0]       iss_rob_tag_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  iq_entry_t                r_q [DEPTH];
  logic [$clog2(DEPTH):0]   r_occ;
  iq_entry_t                w_disp_entry;
  logic [DEPTH-1:0]         w_valid, w_free_oh, w_alloc, w_req, w_grant;
  logic [DEPTH-1:0]         w_s1_hit, w_s2_hit;
  logic                     w_disp_fire, w_iss_any;

  always_comb begin
    logic found;
    found     = 1'b0;
    w_free_oh = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i]  = r_q[i].valid;
      w_s1_hit[i] = cdb_valid_i && !r_q[i].src1_rdy && (r_q[i].src1_tag == cdb_tag_i);
      w_s2_hit[i] = cdb_valid_i && !r_q[i].src2_rdy && (r_q[i].src2_tag == cdb_tag_i);
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
      w_req[i] = r_q[i].valid && (r_q[i].src1_rdy || w_s1_hit[i]) &&
                 (r_q[i].src2_rdy || w_s2_hit[i]);
`else
      w_req[i] = r_q[i].valid && r_q[i].src1_rdy && r_q[i].src2_rdy;
`endif
      if (!r_q[i].valid && !found) begin
        w_free_oh[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign disp_ready_o = ~&w_valid;
  assign w_disp_fire  = disp_valid_i && disp_ready_o && !flush_i;
  assign w_alloc      = w_free_oh & {DEPTH{w_disp_fire}};
  assign w_iss_any    = |w_grant;
  assign iss_valid_o  = w_iss_any && !flush_i;
  assign occupancy_o  = r_occ;

  // Snoop the CDB at dispatch so a broadcast in the dispatch cycle is not lost.
  always_comb begin
    w_disp_entry          = '0;
    w_disp_entry.valid    = 1'b1;
    w_disp_entry.op       = alu_op_e'(disp_op_i);
    w_disp_entry.src1_tag = disp_src1_tag_i;
    w_disp_entry.src2_tag = disp_src2_tag_i;
    w_disp_entry.src1_rdy = disp_src1_rdy_i || (cdb_valid_i && (cdb_tag_i == disp_src1_tag_i));
    w_disp_entry.src2_rdy = disp_src2_rdy_i || (cdb_valid_i && (cdb_tag_i == disp_src2_tag_i));
    w_disp_entry.src1_val = disp_src1_rdy_i ? disp_src1_val_i : cdb_data_i;
    w_disp_entry.src2_val = disp_src2_rdy_i ? disp_src2_val_i : cdb_data_i;
    w_disp_entry.rd_p     = disp_rd_p_i;
    w_disp_entry.rob_tag  = disp_rob_tag_i;
  end

  iq_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush_i),
    .i_alloc (w_alloc),
    .i_free  (w_grant),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    iss_op_o      = '0;
    iss_op1_o     = '0;
    iss_op2_o     = '0;
    iss_rd_p_o    = '0;
    iss_rob_tag_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        iss_op_o      = r_q[i].op;
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
        iss_op1_o     = r_q[i].src1_rdy ? r_q[i].src1_val : cdb_data_i;
        iss_op2_o     = r_q[i].src2_rdy ? r_q[i].src2_val : cdb_data_i;
`else
        iss_op1_o     = r_q[i].src1_val;
        iss_op2_o     = r_q[i].src2_val;
`endif
        iss_rd_p_o    = r_q[i].rd_p;
        iss_rob_tag_o = r_q[i].rob_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_occ <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q[i].valid <= 1'b0;
      end
      r_occ <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_q[i] <= w_disp_entry;
        end else if (r_q[i].valid) begin
          if (w_s1_hit[i]) begin
            r_q[i].src1_rdy <= 1'b1;
            r_q[i].src1_val <= cdb_data_i;
          end
          if (w_s2_hit[i]) begin
            r_q[i].src2_rdy <= 1'b1;
            r_q[i].src2_val <= cdb_data_i;
          end
          if (w_grant[i]) begin
            r_q[i].valid <= 1'b0;
          end
        end
      end
      case ({w_disp_fire, w_iss_any})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue; expectations follow
// IQ_SAME_CYCLE_WAKEUP_EN when the bench is built with it.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        disp_valid_i;
  logic        disp_ready_o;
  logic [2:0]  disp_op_i;
  logic [5:0]  disp_src1_tag_i, disp_src2_tag_i;
  logic        disp_src1_rdy_i, disp_src2_rdy_i;
  logic [31:0] disp_src1_val_i, disp_src2_val_i;
  logic [5:0]  disp_rd_p_i, disp_rob_tag_i;
  logic        cdb_valid_i;
  logic [5:0]  cdb_tag_i;
  logic [31:0] cdb_data_i;
  logic        iss_valid_o;
  logic [2:0]  iss_op_o;
  logic [31:0] iss_op1_o, iss_op2_o;
  logic [5:0]  iss_rd_p_o, iss_rob_tag_o;
  logic [3:0]  occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(8), .PTAG_W(6), .ROB_W(6), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_op_i(disp_op_i),
    .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
    .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
    .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
    .disp_rd_p_i(disp_rd_p_i), .disp_rob_tag_i(disp_rob_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .iss_valid_o(iss_valid_o), .iss_op_o(iss_op_o), .iss_op1_o(iss_op1_o),
    .iss_op2_o(iss_op2_o), .iss_rd_p_o(iss_rd_p_o), .iss_rob_tag_o(iss_rob_tag_o),
    .occupancy_o(occupancy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid_i = 1'b0;
    cdb_valid_i  = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [5:0] t1, input logic r1,
                      input logic [31:0] v1, input logic [5:0] t2, input logic r2,
                      input logic [31:0] v2, input logic [5:0] rob);
    disp_valid_i = 1'b1; disp_op_i = op;
    disp_src1_tag_i = t1; disp_src1_rdy_i = r1; disp_src1_val_i = v1;
    disp_src2_tag_i = t2; disp_src2_rdy_i = r2; disp_src2_val_i = v2;
    disp_rob_tag_i = rob; disp_rd_p_i = rob ^ 6'h20;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid_i = 1'b1; cdb_tag_i = t; cdb_data_i = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    disp_op_i = '0; disp_src1_tag_i = '0; disp_src2_tag_i = '0;
    disp_src1_rdy_i = 1'b0; disp_src2_rdy_i = 1'b0; disp_src1_val_i = '0;
    disp_src2_val_i = '0; disp_rd_p_i = '0; disp_rob_tag_i = '0;
    cdb_tag_i = '0; cdb_data_i = '0;
    #2;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got=%0h exp=0", iss_valid_o); end
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
    n_tests++; if (disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0h exp=1", disp_ready_o); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue();
    disp(3'd0, 6'd1, 1'b1, 32'd10, 6'd2, 1'b1, 32'd20, 6'd4); #1;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_zero_latency got=%0h exp=0", iss_valid_o); end
    tick(); idle(); #1;
    n_tests++; if (occupancy_o !== 4'd1) begin n_fail++; $display("FAIL basic_occ1 got=%0d exp=1", occupancy_o); end
    n_tests++; if (iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid got=%0h exp=1", iss_valid_o); end
    n_tests++; if (iss_op1_o !== 32'd10) begin n_fail++; $display("FAIL basic_op1 got=%0d exp=10", iss_op1_o); end
    n_tests++; if (iss_op2_o !== 32'd20) begin n_fail++; $display("FAIL basic_op2 got=%0d exp=20", iss_op2_o); end
    n_tests++; if (iss_op_o !== 3'd0) begin n_fail++; $display("FAIL basic_op got=%0d exp=0", iss_op_o); end
    n_tests++; if (iss_rob_tag_o !== 6'd4) begin n_fail++; $display("FAIL basic_rob got=%0d exp=4", iss_rob_tag_o); end
    n_tests++; if (iss_rd_p_o !== 6'h24) begin n_fail++; $display("FAIL basic_rd got=%0h exp=24", iss_rd_p_o); end
    tick();
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL basic_occ0 got=%0d exp=0", occupancy_o); end
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%0h exp=0", iss_valid_o); end
  endtask

  task automatic test_wakeup();
    disp(3'd1, 6'd5, 1'b0, 32'd0, 6'd6, 1'b1, 32'd3, 6'd7);
    tick(); idle(); #1;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_waiting got=%0h exp=0", iss_valid_o); end
    cdb(6'd5, 32'h77); #1;
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
    n_tests++; if (iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL wake_iss_valid got=%0h exp=1", iss_valid_o); end
    n_tests++; if (iss_op1_o !== 32'h77) begin n_fail++; $display("FAIL wake_op1 got=%0h exp=77", iss_op1_o); end
    tick(); idle();
`else
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_bubble got=%0h exp=0", iss_valid_o); end
    tick(); idle(); #1;
    n_tests++; if (iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL wake_iss_valid got=%0h exp=1", iss_valid_o); end
    n_tests++; if (iss_op1_o !== 32'h77) begin n_fail++; $display("FAIL wake_op1 got=%0h exp=77", iss_op1_o); end
    n_tests++; if (iss_op_o !== 3'd1) begin n_fail++; $display("FAIL wake_op got=%0d exp=1", iss_op_o); end
    tick();
`endif
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL wake_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      disp(3'd0, 6'(20 + i), 1'b0, 32'd0, 6'd40, 1'b1, 32'(i), 6'(i));
      tick();
    end
    disp(3'd0, 6'd29, 1'b0, 32'd0, 6'd40, 1'b1, 32'd9, 6'd9); #1;
    n_tests++; if (occupancy_o !== 4'd8) begin n_fail++; $display("FAIL full_occ got=%0d exp=8", occupancy_o); end
    n_tests++; if (disp_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0h exp=0", disp_ready_o); end
    tick();
    n_tests++; if (occupancy_o !== 4'd8) begin n_fail++; $display("FAIL full_held got=%0d exp=8", occupancy_o); end
    cdb(6'd23, 32'h33); #1;
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
    n_tests++; if (iss_rob_tag_o !== 6'd3 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_iss3 got=%0d/%0h exp=3/1", iss_rob_tag_o, iss_valid_o); end
    tick(); cdb_valid_i = 1'b0; #1;
`else
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_bubble got=%0h exp=0", iss_valid_o); end
    tick(); cdb_valid_i = 1'b0; #1;
    n_tests++; if (iss_rob_tag_o !== 6'd3 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_iss3 got=%0d/%0h exp=3/1", iss_rob_tag_o, iss_valid_o); end
    n_tests++; if (iss_op1_o !== 32'h33) begin n_fail++; $display("FAIL full_op1 got=%0h exp=33", iss_op1_o); end
    n_tests++; if (disp_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_issue_cycle got=%0h exp=0", disp_ready_o); end
    tick();
`endif
    n_tests++; if (disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%0h exp=1", disp_ready_o); end
    n_tests++; if (occupancy_o !== 4'd7) begin n_fail++; $display("FAIL full_occ7 got=%0d exp=7", occupancy_o); end
    tick();
    n_tests++; if (occupancy_o !== 4'd8) begin n_fail++; $display("FAIL full_refill got=%0d exp=8", occupancy_o); end
    idle(); flush_i = 1'b1;
    tick(); idle(); #1;
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL full_flush_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_oldest_first();
    disp(3'd0, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2, 6'd15);
    tick();
    disp(3'd0, 6'd9, 1'b0, 32'd0, 6'd2, 1'b1, 32'hA, 6'd10); #1;
    n_tests++; if (iss_rob_tag_o !== 6'd15 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL old_filler got=%0d/%0h exp=15/1", iss_rob_tag_o, iss_valid_o); end
    tick();
    disp(3'd3, 6'd9, 1'b0, 32'd0, 6'd2, 1'b1, 32'hB, 6'd11); #1;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL old_waiting got=%0h exp=0", iss_valid_o); end
    tick(); idle(); cdb(6'd9, 32'h99); #1;
`ifdef IQ_SAME_CYCLE_WAKEUP_EN
    n_tests++; if (iss_rob_tag_o !== 6'd10 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL old_first got=%0d/%0h exp=10/1", iss_rob_tag_o, iss_valid_o); end
    tick(); cdb_valid_i = 1'b0; #1;
`else
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL old_bubble got=%0h exp=0", iss_valid_o); end
    tick(); cdb_valid_i = 1'b0; #1;
    n_tests++; if (iss_rob_tag_o !== 6'd10 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL old_first got=%0d/%0h exp=10/1", iss_rob_tag_o, iss_valid_o); end
    n_tests++; if (iss_op1_o !== 32'h99) begin n_fail++; $display("FAIL old_op1 got=%0h exp=99", iss_op1_o); end
    tick();
`endif
    n_tests++; if (iss_rob_tag_o !== 6'd11 || iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL old_second got=%0d/%0h exp=11/1", iss_rob_tag_o, iss_valid_o); end
    n_tests++; if (iss_op_o !== 3'd3) begin n_fail++; $display("FAIL old_second_op got=%0d exp=3", iss_op_o); end
    tick();
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL old_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_dispatch_snoop();
    disp(3'd2, 6'd11, 1'b1, 32'hF0, 6'd12, 1'b0, 32'd0, 6'd12);
    cdb(6'd12, 32'hAB); #1;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL snoop_same_cycle got=%0h exp=0", iss_valid_o); end
    tick(); idle(); #1;
    n_tests++; if (iss_valid_o !== 1'b1) begin n_fail++; $display("FAIL snoop_iss_valid got=%0h exp=1", iss_valid_o); end
    n_tests++; if (iss_op2_o !== 32'hAB) begin n_fail++; $display("FAIL snoop_op2 got=%0h exp=ab", iss_op2_o); end
    n_tests++; if (iss_op1_o !== 32'hF0) begin n_fail++; $display("FAIL snoop_op1 got=%0h exp=f0", iss_op1_o); end
    tick();
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL snoop_occ got=%0d exp=0", occupancy_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      disp(3'd4, 6'd30, 1'b0, 32'd0, 6'd31, 1'b0, 32'd0, 6'(20 + i));
      tick();
    end
    disp(3'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd6, 6'd24);
    tick();
    disp(3'd0, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd8, 6'd25);
    flush_i = 1'b1; #1;
    n_tests++; if (occupancy_o !== 4'd5) begin n_fail++; $display("FAIL flush_pre_occ got=%0d exp=5", occupancy_o); end
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_iss_forced got=%0h exp=0", iss_valid_o); end
    tick(); idle(); #1;
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy_o); end
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got=%0h exp=0", iss_valid_o); end
    tick();
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_stays_empty got=%0h exp=0", iss_valid_o); end
  endtask

  task automatic test_async_reset();
    disp(3'd0, 6'd50, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd30);
    tick();
    disp(3'd0, 6'd50, 1'b0, 32'd0, 6'd2, 1'b1, 32'd2, 6'd31);
    tick(); idle(); #1;
    n_tests++; if (occupancy_o !== 4'd2) begin n_fail++; $display("FAIL areset_pre_occ got=%0d exp=2", occupancy_o); end
    rst_n = 1'b0; #1;
    n_tests++; if (occupancy_o !== 4'd0) begin n_fail++; $display("FAIL areset_occ got=%0d exp=0", occupancy_o); end
    n_tests++; if (disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ready got=%0h exp=1", disp_ready_o); end
    tick();
    rst_n = 1'b1;
    cdb(6'd50, 32'h5);
    tick(); idle(); #1;
    n_tests++; if (iss_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_entries_gone got=%0h exp=0", iss_valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_oldest_first();
    test_dispatch_snoop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
